// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu - 8-bit, 8-operation arithmetic/logic unit for the ProtoCore datapath.
//
// The result and flags are purely combinational functions of a, b and opcode.
// A 2-bit status register samples {carry, zero} on every rising clock edge so
// that later branch logic can consume the flags one cycle after they were
// produced.
//
// Ports:
//   clk     in   1  system clock, rising-edge active
//   rst     in   1  synchronous active-high reset; clears flags_q only
//   a       in   8  operand A
//   b       in   8  operand B (unused by NOT, SHL, SHR)
//   opcode  in   3  000 ADD, 001 SUB, 010 AND, 011 OR,
//                   100 XOR, 101 NOT, 110 SHL, 111 SHR
//   out     out  8  result (combinational)
//   carry   out  1  carry / borrow / shifted-out bit (combinational)
//   zero    out  1  out == 0 (combinational)
//   flags_q out  2  registered {carry, zero}
// -----------------------------------------------------------------------------
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] opcode,
    output logic [7:0] out,
    output logic       carry,
    output logic       zero,
    output logic [1:0] flags_q
);

    // 9-bit working result: bit 8 is the carry column for every opcode.
    logic [8:0] res;

    always_comb begin
        res = 9'd0;
        case (opcode)
            3'b000:  res = {1'b0, a} + {1'b0, b};
            // Zero-extended 9-bit subtraction wraps to bit 8 = 1 exactly when
            // a < b, which is the borrow.
            3'b001:  res = {1'b0, a} - {1'b0, b};
            3'b010:  res = {1'b0, a & b};
            3'b011:  res = {1'b0, a | b};
            3'b100:  res = {1'b0, a ^ b};
            3'b101:  res = {1'b0, ~a};
            3'b110:  res = {a, 1'b0};
            // Logical right shift: a[0] falls into the carry column, MSB fills 0.
            default: res = {a[0], 1'b0, a[7:1]};
        endcase
    end

    assign out   = res[7:0];
    assign carry = res[8];
    assign zero  = (res[7:0] == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) flags_q <= 2'b00;
        else     flags_q <= {carry, zero};
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] opcode = 3'd0;
    logic [7:0] out;
    logic       carry;
    logic       zero;
    logic [1:0] flags_q;

    int checks = 0;
    int errors = 0;

    logic [1:0] pend_flags = 2'b00;
    bit         pend_vld   = 1'b0;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .opcode  (opcode),
        .out     (out),
        .carry   (carry),
        .zero    (zero),
        .flags_q (flags_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s op=%0d a=%02h b=%02h got=%02h exp=%02h",
                     tag, opcode, a, b, got, exp);
        end
    endtask

    // Reference model from the opcode table, using integer arithmetic.
    function automatic void model(input int op, input int x, input int y,
                                  output int o, output int c);
        o = 0; c = 0;
        case (op)
            0: begin o = (x + y) % 256;       c = (x + y) > 255 ? 1 : 0; end
            1: begin o = (x - y + 256) % 256; c = (x < y) ? 1 : 0;       end
            2: o = x & y;
            3: o = x | y;
            4: o = x ^ y;
            5: o = 255 - x;
            6: begin o = (x * 2) % 256;       c = x / 128;               end
            default: begin o = x / 2;         c = x % 2;                 end
        endcase
    endfunction

    // Drive one vector at the falling edge; first confirm the flags captured
    // at the previous rising edge, then check the combinational outputs.
    task automatic apply(input int op, input int x, input int y, input bit r);
        int o, c;
        @(negedge clk);
        if (pend_vld) chk("flags_q", {6'd0, flags_q}, {6'd0, pend_flags});
        opcode = op[2:0]; a = x[7:0]; b = y[7:0]; rst = r;
        #1;
        model(op, x, y, o, c);
        chk("out",   out,          o[7:0]);
        chk("carry", {7'd0, carry}, c[7:0]);
        chk("zero",  {7'd0, zero},  (o == 0) ? 8'd1 : 8'd0);
        pend_flags = r ? 2'b00 : {c[0], (o == 0)};
        pend_vld   = 1'b1;
    endtask

    initial begin
        // Reset held for an edge, then ADD 80+80 shows up as 11 one cycle later.
        apply(0, 'h80, 'h80, 1);
        apply(0, 'h80, 'h80, 0);
        apply(0, 'h01, 'h02, 0);

        // Directed vectors.
        apply(1, 'h01, 'h80, 0);
        apply(1, 'h80, 'h80, 0);
        apply(2, 'h11, 'h33, 0);
        apply(3, 'h11, 'h66, 0);
        apply(4, 'h33, 'h33, 0);
        apply(5, 'h11, 'h00, 0);
        apply(6, 'h88, 'h00, 0);
        apply(7, 'h11, 'h00, 0);
        apply(7, 'hFF, 'h00, 0);
        apply(6, 'h80, 'h00, 0);
        apply(5, 'hFF, 'h5A, 0);

        // Reset mid-stream: out unchanged, flags cleared on that edge.
        apply(0, 'h80, 'h80, 0);
        apply(0, 'h80, 'h80, 1);
        apply(0, 'h80, 'h80, 0);

        // Power-of-two sweeps for ADD and SUB.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                apply(0, 1 << i, 1 << j, 0);
                apply(1, 1 << i, 1 << j, 0);
            end

        // Logic sweep.
        for (int op = 2; op < 6; op++)
            for (int x = 0; x <= 255; x += 'h11)
                for (int y = 0; y <= 255; y += 'h33)
                    apply(op, x, y, 0);

        // Randomized vectors, occasional reset.
        for (int n = 0; n < 400; n++)
            apply($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 19) == 0));

        @(negedge clk);
        chk("flags_q", {6'd0, flags_q}, {6'd0, pend_flags});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
